// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: preloadable memory, CPI-cycle slots, halt detection
module instr_fetch #(
    parameter int              D       = 12,
    parameter int              W       = 9,
    parameter int              CPI     = 5,
    parameter logic [W-1:0]    HALT_OP = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    input  logic         start,
    input  logic         load_en,
    input  logic [D-1:0] load_addr,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] instr,
    output logic         instr_valid,
    output logic [D-1:0] fetch_addr,
    output logic [2:0]   phase,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [2:0] LAST_PHASE = 3'(CPI - 1);

    state_t       state, next_state;
    logic [W-1:0] mem [0:(1 << D) - 1];
    logic [D-1:0] addr_q;
    logic [W-1:0] rd_word;
    logic         sample_edge;
    logic         fetch_edge;
    logic         halt_hit;

    assign rd_word     = mem[addr_q];
    assign sample_edge = (state == RUN) && (phase == 3'd0);
    assign fetch_edge  = (state == RUN) && (phase == 3'd1);
    // The halt word is recognised on the same edge that loads it into instr.
    assign halt_hit    = fetch_edge && (rd_word == HALT_OP);
    assign busy        = (state == RUN);

    // Program memory has no reset so a preload survives a reset pulse.
    always_ff @(posedge clk) begin
        if (load_en && (state != RUN)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (halt_hit) next_state = HALT;
            HALT:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= 3'd0;
            addr_q      <= '0;
            instr       <= '0;
            fetch_addr  <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if ((state == RUN) && !halt_hit) begin
                phase <= (phase == LAST_PHASE) ? 3'd0 : phase + 3'd1;
            end else begin
                phase <= 3'd0;
            end
            if (sample_edge) begin
                addr_q <= prog_ctr;
            end
            if (fetch_edge) begin
                instr       <= rd_word;
                fetch_addr  <= addr_q;
                instr_valid <= 1'b1;
            end
            if (halt_hit) begin
                done <= 1'b1;
            end else if ((state == HALT) && start) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed table-driven bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [11:0] prog_ctr;
    logic        start;
    logic        load_en;
    logic [11:0] load_addr;
    logic [8:0]  load_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [11:0] fetch_addr;
    logic [2:0]  phase;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.D(12), .W(9), .CPI(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_ctr   (prog_ctr),
        .start      (start),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .fetch_addr (fetch_addr),
        .phase      (phase),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0] pc0;
        logic [11:0] pc1;
        logic        ld_run;
        logic [8:0]  exp_instr;
        logic [11:0] exp_addr;
        logic        exp_halt;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [11:0] a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Entered at a negedge inside a phase-0 cycle; leaves at the next phase-0 cycle
    // or, for a halt word, at the first cycle in HALT.
    task automatic do_slot(input vec_t v);
        chk("slot_phase0", {29'd0, phase}, 32'd0);
        prog_ctr = v.pc0;
        if (v.ld_run) begin
            load_en   = 1'b1;
            load_addr = 12'd2;
            load_data = 9'h0AA;
        end
        tick();
        load_en  = 1'b0;
        prog_ctr = v.pc1;
        chk("valid_phase1", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("valid_pulse", {31'd0, instr_valid}, 32'd1);
        chk("instr", {23'd0, instr}, {23'd0, v.exp_instr});
        chk("fetch_addr", {20'd0, fetch_addr}, {20'd0, v.exp_addr});
        chk("done", {31'd0, done}, {31'd0, v.exp_halt});
        chk("busy", {31'd0, busy}, {31'd0, !v.exp_halt});
        if (!v.exp_halt) begin
            chk("phase2", {29'd0, phase}, 32'd2);
            tick();
            chk("valid_phase3", {31'd0, instr_valid}, 32'd0);
            tick();
            tick();
        end else begin
            chk("halt_phase", {29'd0, phase}, 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        prog_ctr  = '0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        vecs[0] = '{12'd0, 12'd0, 1'b0, 9'h011, 12'd0, 1'b0};
        vecs[1] = '{12'd1, 12'd1, 1'b0, 9'h022, 12'd1, 1'b0};
        vecs[2] = '{12'd5, 12'd9, 1'b1, 9'h055, 12'd5, 1'b0};
        vecs[3] = '{12'd2, 12'd2, 1'b0, 9'h033, 12'd2, 1'b0};
        vecs[4] = '{12'd3, 12'd3, 1'b0, 9'h1FF, 12'd3, 1'b1};

        tick();
        tick();
        chk("rst_instr", {23'd0, instr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fetch_addr", {20'd0, fetch_addr}, 32'd0);
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();

        load_word(12'd0, 9'h011);
        load_word(12'd1, 9'h022);
        load_word(12'd2, 9'h033);
        load_word(12'd3, 9'h1FF);
        load_word(12'd5, 9'h055);
        load_word(12'd9, 9'h099);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_slot(vecs[i]);
        end

        // HALT holds everything with no further pulses
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        end
        chk("halt_instr", {23'd0, instr}, 32'h1FF);
        chk("halt_fetch_addr", {20'd0, fetch_addr}, 32'd3);
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_phase_hold", {29'd0, phase}, 32'd0);

        // Patch and resume
        load_word(12'd3, 9'h044);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_done", {31'd0, done}, 32'd0);
        chk("resume_busy", {31'd0, busy}, 32'd1);
        do_slot('{12'd3, 12'd3, 1'b0, 9'h044, 12'd3, 1'b0});
        chk("resume_busy_after", {31'd0, busy}, 32'd1);

        // Asynchronous reset during phase 1
        prog_ctr = 12'd1;
        tick();
        chk("pre_rst_phase", {29'd0, phase}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_instr", {23'd0, instr}, 32'd0);
        chk("arst_phase", {29'd0, phase}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_fetch_addr", {20'd0, fetch_addr}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("arst_no_resume", {31'd0, busy}, 32'd0);
        chk("arst_no_valid", {31'd0, instr_valid}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        do_slot('{12'd0, 12'd0, 1'b0, 9'h011, 12'd0, 1'b0});

        // Start and load in the same IDLE cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 12'd0;
        load_data = 9'h077;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        chk("sim_busy", {31'd0, busy}, 32'd1);
        do_slot('{12'd0, 12'd0, 1'b0, 9'h077, 12'd0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
